// File: rtl/sst_pkg.sv
// sst_pkg -- shared definitions for the save-state sequencer.
//   sst_state_t      : sequencer FSM state encoding
//   SST_MODE_SAVE/LOAD : values of the latched mode bit
//   SST_ADDR_*_DEF   : default save-state address bounds
//   sst_neg()        : two's complement of a byte (checksum trailer)
package sst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SETTLE,
        ST_XFER,
        ST_WSTB,
        ST_NEXT,
        ST_CSUM,
        ST_DONE
    } sst_state_t;

    localparam logic SST_MODE_SAVE = 1'b0;
    localparam logic SST_MODE_LOAD = 1'b1;

    localparam logic [7:0] SST_ADDR_FIRST_DEF = 8'd0;
    localparam logic [7:0] SST_ADDR_LAST_DEF  = 8'd255;

    function automatic logic [7:0] sst_neg(input logic [7:0] b);
        return 8'(~b + 8'd1);
    endfunction

endpackage

// File: rtl/sst_csum.sv
// sst_csum -- 8-bit running-sum accumulator (mod 256).
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : clear the sum to 0 (wins over add_i)
//   add_i    : add dat_i to the sum this clock
//   dat_i    : byte to accumulate
//   sum_o    : current sum
//   zero_o   : current sum is zero
module sst_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       add_i,
    input  logic [7:0] dat_i,
    output logic [7:0] sum_o,
    output logic       zero_o
);

    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + dat_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o  = sum_q;
    assign zero_o = (sum_q == '0);

endmodule

// File: rtl/sst_seq.sv
// sst_seq -- save-state sequencer (initiator of the mapper save-state bus).
// Walks ADDR_FIRST..ADDR_LAST; save mode reads each byte from the bus and
// streams it to the host, load mode takes host bytes and strobes them onto
// the bus.
// Optional feature macro: SST_CSUM_EN (adds a mod-256 checksum trailer byte,
// generated on save and verified on load).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, mode       : command pulse and its mode (0 save, 1 load)
//   abort             : level, returns to IDLE and flags err
//   busy, done, err   : status
//   sst_act           : bus active (responders freeze)
//   sst_we_reg        : one-cycle register write strobe
//   sst_addr, sst_dato: bus address / write data
//   sst_rdat          : combinational read data from responders
//   tx_data/valid/ready : save stream to host
//   rx_data/valid/ready : load stream from host
module sst_seq
    import sst_pkg::*;
#(
    parameter logic [7:0]  ADDR_FIRST = SST_ADDR_FIRST_DEF,
    parameter logic [7:0]  ADDR_LAST  = SST_ADDR_LAST_DEF,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       sst_act,
    output logic       sst_we_reg,
    output logic [7:0] sst_addr,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_rdat,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam logic [2:0] SETTLE_LD = 3'(SETTLE_CYC - 1);

    sst_state_t state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] dato_q, dato_d;
    logic [7:0] txd_q, txd_d;
    logic [2:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic       err_q, err_d;

    logic       tx_hs, rx_hs;

    assign tx_hs = tx_valid & tx_ready;
    assign rx_hs = rx_ready & rx_valid;

`ifdef SST_CSUM_EN
    logic [7:0] csum_sum;
    logic       csum_zero;
    logic       csum_clr;
    logic       csum_add;
    logic [7:0] csum_dat;
    logic       csum_fail;

    assign csum_clr  = (state_q == ST_IDLE) && start && !abort;
    assign csum_add  = tx_hs | rx_hs;
    assign csum_dat  = (mode_q == SST_MODE_LOAD) ? rx_data : txd_q;
    // Load trailer has been folded into the sum by the time DONE is reached.
    assign csum_fail = (state_q == ST_DONE) && (mode_q == SST_MODE_LOAD) && !csum_zero;

    sst_csum u_csum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (csum_clr),
        .add_i  (csum_add),
        .dat_i  (csum_dat),
        .sum_o  (csum_sum),
        .zero_o (csum_zero)
    );
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            dato_q  <= '0;
            txd_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= SST_MODE_SAVE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dato_q  <= dato_d;
            txd_q   <= txd_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dato_d  = dato_q;
        txd_d   = txd_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = err_q;

        if ((state_q != ST_IDLE) && abort) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        mode_d  = mode;
                        err_d   = 1'b0;
                        addr_d  = ADDR_FIRST;
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    cnt_d   = SETTLE_LD;
                    state_d = (mode_q == SST_MODE_LOAD) ? ST_XFER : ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Sample read data on the edge that leaves SETTLE so it is
                    // already registered and stable for the whole of XFER.
                    if (cnt_q == '0) begin
                        txd_d   = sst_rdat;
                        state_d = ST_XFER;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                ST_XFER: begin
                    if (mode_q == SST_MODE_SAVE) begin
                        if (tx_hs) begin
                            state_d = ST_NEXT;
                        end
                    end else if (rx_hs) begin
                        dato_d  = rx_data;
                        state_d = ST_WSTB;
                    end
                end
                ST_WSTB: begin
                    state_d = ST_NEXT;
                end
                ST_NEXT: begin
                    // Compare before incrementing so ADDR_LAST=255 never wraps.
                    if (addr_q == ADDR_LAST) begin
`ifdef SST_CSUM_EN
                        txd_d   = sst_neg(csum_sum);
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        cnt_d   = SETTLE_LD;
                        state_d = (mode_q == SST_MODE_LOAD) ? ST_XFER : ST_SETTLE;
                    end
                end
`ifdef SST_CSUM_EN
                ST_CSUM: begin
                    if (tx_hs || rx_hs) begin
                        state_d = ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
`ifdef SST_CSUM_EN
                    if (csum_fail) begin
                        err_d = 1'b1;
                    end
`endif
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs; stream handshakes are withdrawn combinationally on abort,
    // the write strobe is not.
    always_comb begin
        busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        sst_act    = busy;
        done       = (state_q == ST_DONE) && !abort;
        sst_we_reg = (state_q == ST_WSTB);
        tx_valid   = !abort && (mode_q == SST_MODE_SAVE) &&
                     ((state_q == ST_XFER) || (state_q == ST_CSUM));
        rx_ready   = !abort && (mode_q == SST_MODE_LOAD) &&
                     ((state_q == ST_XFER) || (state_q == ST_CSUM));
        sst_addr   = (state_q == ST_IDLE) ? '0 : addr_q;
        sst_dato   = (state_q == ST_IDLE) ? '0 : dato_q;
        tx_data    = (state_q == ST_IDLE) ? '0 : txd_q;
`ifdef SST_CSUM_EN
        err        = err_q | csum_fail;
`else
        err        = err_q;
`endif
    end

endmodule

// File: tb/tb_sst_seq.sv
module tb_sst_seq;

`ifdef SST_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int SAVE_CYC = 256 * (2 + 2) + 2 + CS;
    localparam int LOAD_CYC = 1 + 256 * 3 + 1 + CS;

    logic       clk = 1'b0;
    logic       rst, start, mode, abort;
    logic       busy, done, err, sst_act, sst_we_reg;
    logic [7:0] sst_addr, sst_dato, sst_rdat, tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;

    sst_seq #(.ADDR_FIRST(8'd0), .ADDR_LAST(8'd255), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .done(done), .err(err), .sst_act(sst_act),
        .sst_we_reg(sst_we_reg), .sst_addr(sst_addr), .sst_dato(sst_dato),
        .sst_rdat(sst_rdat), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    // Responder model: read data is a fixed function of the address.
    assign sst_rdat = sst_addr ^ 8'h5A;

    logic [7:0] mem [256];
    always @(posedge clk) if (sst_we_reg) mem[sst_addr] <= sst_dato;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input int act);
        total++;
        bad++;
        $display("FAIL %s actual=%0d required=none", nm, act);
    endtask

    // Scoreboard
    logic [7:0]  exp_tx_q [$];
    logic [15:0] exp_wr_q [$];
    int          we_cnt;
    bit          sb_on = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_txd;

    always @(negedge clk) begin
        if (!sb_on || rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("tx_hold_valid", tx_valid, 1'b1);
                chk("tx_hold_data", tx_data, prev_txd);
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx_q.size() == 0) fail_now("tx_extra_byte", tx_data);
                else chk("tx_byte", tx_data, exp_tx_q.pop_front());
            end
            prev_stall = tx_valid && !tx_ready;
            prev_txd   = tx_data;
            if (sst_we_reg) begin
                logic [15:0] e;
                we_cnt++;
                if (exp_wr_q.size() == 0) fail_now("we_extra", sst_addr);
                else begin
                    e = exp_wr_q.pop_front();
                    chk("we_addr", sst_addr, e[15:8]);
                    chk("we_data", sst_dato, e[7:0]);
                end
            end
        end
    end

    function automatic logic [7:0] rxd(input int idx, input logic [7:0] xr, input logic [7:0] adj);
        // Sum of any 256-byte permutation of 0..255 is 0x80, so trailer is 0x80.
        if (idx < 256) return 8'(idx) ^ xr;
        return 8'h80 + adj;
    endfunction

    // One command from start to done (or to an abort/reset event at ev_addr).
    task automatic run(input logic md, input bit tog, input int ev_addr, input bit ev_rst,
                       input logic [7:0] xr, input logic [7:0] adj,
                       output int done_at, output int first_v, output logic err_at);
        bit hs;
        int idx;
        done_at = -1; first_v = -1; err_at = 1'bx; idx = 0; hs = 0;
        @(posedge clk); #1;
        start = 1; mode = md; rx_valid = md; rx_data = rxd(0, xr, adj); tx_ready = 1;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                start = 0;
                if (hs) begin idx++; rx_data = rxd(idx, xr, adj); end
                if (tog) tx_ready = (cyc % 3 == 0);
            end
            @(negedge clk);
            hs = rx_valid && rx_ready;
            if (tx_valid && first_v < 0) first_v = cyc;
            if (done) begin
                done_at = cyc;
                err_at  = err;
                chk("busy_at_done", busy, 1'b0);
                break;
            end
            if (ev_addr >= 0 && sst_addr == 8'(ev_addr) && (ev_rst ? tx_valid : rx_ready)) begin
                if (ev_rst) begin
                    rst = 1; #1;
                    chk("rst_outs_zero", {busy, done, err, sst_act, sst_we_reg, sst_addr,
                                          sst_dato, tx_data, tx_valid, rx_ready}, '0);
                end else begin
                    abort = 1; #1;
                    chk("abort_rx_ready_drop", rx_ready, 1'b0);
                end
                @(posedge clk); #1;
                abort = 0; rst = 0;
                @(negedge clk);
                chk("ev_busy", busy, 1'b0);
                chk("ev_done", done, 1'b0);
                chk("ev_err", err, ev_rst ? 1'b0 : 1'b1);
                return;
            end
        end
        tx_ready = 1; rx_valid = 0;
    endtask

    typedef struct {
        logic st, md, ab;
        logic busy, act, txv, rxr, err, done;
        logic [7:0] addr, txd;
    } vec_t;

    vec_t tv [20];
    int   d_at, f_v, nbad;
    logic e_at;

    initial begin
        rst = 1; start = 0; mode = 0; abort = 0;
        tx_ready = 1; rx_valid = 0; rx_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("reset_outs", {busy, done, err, sst_act, sst_we_reg, sst_addr, sst_dato,
                           tx_data, tx_valid, rx_ready}, '0);

        //            st md ab  busy act txv rxr err done addr   txd
        tv[0]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h00};
        tv[1]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h00};
        tv[2]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h00};
        tv[3]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h00};
        tv[4]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h00};
        tv[5]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 8'h00, 8'h5A};
        tv[6]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h00};
        tv[7]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h01, 8'h00};
        tv[8]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h01, 8'h00};
        tv[9]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 8'h01, 8'h5B};
        tv[10] = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h01, 8'h00};
        tv[11] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00, 8'h00};
        tv[12] = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00, 8'h00};
        tv[13] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00, 8'h00};
        tv[14] = '{1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00, 8'h00};
        tv[15] = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h00};
        tv[16] = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 8'h00, 8'h00};
        tv[17] = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 8'h00, 8'h00};
        tv[18] = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 8'h00};
        tv[19] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00, 8'h00};

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            start = tv[i].st; mode = tv[i].md; abort = tv[i].ab;
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), busy, tv[i].busy);
            chk($sformatf("vec%0d_act", i), sst_act, tv[i].act);
            chk($sformatf("vec%0d_txv", i), tx_valid, tv[i].txv);
            chk($sformatf("vec%0d_rxr", i), rx_ready, tv[i].rxr);
            chk($sformatf("vec%0d_err", i), err, tv[i].err);
            chk($sformatf("vec%0d_done", i), done, tv[i].done);
            chk($sformatf("vec%0d_addr", i), sst_addr, tv[i].addr);
            if (tv[i].txv) chk($sformatf("vec%0d_txd", i), tx_data, tv[i].txd);
        end
        @(posedge clk); #1;
        start = 0; abort = 0; mode = 0;

        // Full load 0x00..0xFF, rx_valid held high
        exp_wr_q.delete(); we_cnt = 0; sb_on = 1;
        for (int i = 0; i < 256; i++) exp_wr_q.push_back({8'(i), 8'(i)});
        run(1'b1, 1'b0, -1, 1'b0, 8'h00, 8'h00, d_at, f_v, e_at);
        chk("load_done_cycle", d_at, LOAD_CYC);
        chk("load_err", e_at, 1'b0);
        chk("load_we_count", we_cnt, 256);
        chk("load_wr_left", exp_wr_q.size(), 0);
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) nbad++;
        chk("load_mem_image", nbad, 0);

        // Full save, tx_ready held high
        exp_tx_q.delete();
        for (int i = 0; i < 256; i++) exp_tx_q.push_back(8'(i) ^ 8'h5A);
        if (CS != 0) exp_tx_q.push_back(8'h80);
        run(1'b0, 1'b0, -1, 1'b0, 8'h00, 8'h00, d_at, f_v, e_at);
        chk("save_first_valid", f_v, 4);
        chk("save_done_cycle", d_at, SAVE_CYC);
        chk("save_err", e_at, 1'b0);
        chk("save_tx_left", exp_tx_q.size(), 0);

        // Save with tx_ready high one cycle in three
        exp_tx_q.delete();
        for (int i = 0; i < 256; i++) exp_tx_q.push_back(8'(i) ^ 8'h5A);
        if (CS != 0) exp_tx_q.push_back(8'h80);
        run(1'b0, 1'b1, -1, 1'b0, 8'h00, 8'h00, d_at, f_v, e_at);
        chk("save_tog_done_seen", d_at > 0, 1'b1);
        chk("save_tog_tx_left", exp_tx_q.size(), 0);

        // Load aborted at address 0x40
        exp_wr_q.delete(); we_cnt = 0;
        for (int i = 0; i < 'h40; i++) exp_wr_q.push_back({8'(i), 8'(i) ^ 8'hC3});
        run(1'b1, 1'b0, 'h40, 1'b0, 8'hC3, 8'h00, d_at, f_v, e_at);
        chk("abort_no_done", d_at, -1);
        chk("abort_we_count", we_cnt, 'h40);
        chk("abort_wr_left", exp_wr_q.size(), 0);
        rx_valid = 0;
        nbad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ((i < 'h40) ? (8'(i) ^ 8'hC3) : 8'(i))) nbad++;
        chk("abort_mem_image", nbad, 0);

        // Reset mid-save at address 0x10, then a clean rerun
        exp_tx_q.delete();
        for (int i = 0; i < 256; i++) exp_tx_q.push_back(8'(i) ^ 8'h5A);
        run(1'b0, 1'b0, 'h10, 1'b1, 8'h00, 8'h00, d_at, f_v, e_at);
        chk("rst_no_done", d_at, -1);
        chk("rst_tx_left", exp_tx_q.size(), 256 - 'h10);
        exp_tx_q.delete();
        for (int i = 0; i < 256; i++) exp_tx_q.push_back(8'(i) ^ 8'h5A);
        if (CS != 0) exp_tx_q.push_back(8'h80);
        run(1'b0, 1'b0, -1, 1'b0, 8'h00, 8'h00, d_at, f_v, e_at);
        chk("rerun_first_valid", f_v, 4);
        chk("rerun_done_cycle", d_at, SAVE_CYC);
        chk("rerun_tx_left", exp_tx_q.size(), 0);

`ifdef SST_CSUM_EN
        // Load with the checksum trailer off by one
        exp_wr_q.delete(); we_cnt = 0;
        for (int i = 0; i < 256; i++) exp_wr_q.push_back({8'(i), 8'(i)});
        run(1'b1, 1'b0, -1, 1'b0, 8'h00, 8'h01, d_at, f_v, e_at);
        chk("csum_bad_done_cycle", d_at, LOAD_CYC);
        chk("csum_bad_err", e_at, 1'b1);
        @(negedge clk);
        chk("csum_bad_err_sticky", err, 1'b1);
`endif

        sb_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
